// File: rtl/nco_tune_ctrl_if.sv
// Tuning request/response bundle between requesters, the NCO and nco_tune_ctrl.
// master = requester/NCO side, slave = controller side.
interface nco_tune_ctrl_if #(
   parameter int PHI_W = 32
);
   logic             req0_valid;
   logic [PHI_W-1:0] req0_phi;
   logic             req0_ready;
   logic             req1_valid;
   logic [PHI_W-1:0] req1_phi;
   logic             req1_ready;
   logic             nco_out_valid;
   logic [PHI_W-1:0] phi_inc_o;
   logic             busy;
   logic             tuned;
   logic             tuned_src;

   modport master (
      output req0_valid, req0_phi, req1_valid, req1_phi, nco_out_valid,
      input  req0_ready, req1_ready, phi_inc_o, busy, tuned, tuned_src
   );

   modport slave (
      input  req0_valid, req0_phi, req1_valid, req1_phi, nco_out_valid,
      output req0_ready, req1_ready, phi_inc_o, busy, tuned, tuned_src
   );
endinterface

// File: rtl/nco_tune_ctrl.sv
// NCO tuning controller: round-robin arbitration of two phase-increment requesters,
// apply, settle-count on NCO out_valid, tuned pulse. NCO_TUNE_SLEW_EN adds rate-limited ramping.
module nco_tune_ctrl #(
   parameter int               PHI_W     = 32,
   parameter int               LAT       = 8,
`ifdef NCO_TUNE_SLEW_EN
   parameter logic [PHI_W-1:0] STEP_MAX  = 32'h0010_0000,
`endif
   parameter logic [PHI_W-1:0] RESET_PHI = 32'h5000_0000
) (
   input logic           clk,
   input logic           reset,
   nco_tune_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, SETTLE = 2'd2} state_t;

   localparam logic [7:0] LAT_M1 = 8'(LAT - 1);

   state_t           r_state;
   state_t           w_next;
   logic [PHI_W-1:0] r_phi;
   logic             r_src;
   logic             r_last;
   logic             r_tuned;
   logic             r_tuned_src;
   logic [7:0]       r_cnt;

   logic             w_grant0;
   logic             w_grant1;
   logic             w_xfer;
   logic             w_sel;
   logic             w_equal;
   logic             w_done;
   logic [PHI_W-1:0] w_req_phi;

`ifdef NCO_TUNE_SLEW_EN
   logic [PHI_W-1:0] r_target;
   logic [PHI_W-1:0] w_step;

   // Move at most STEP_MAX toward tgt; lands exactly on tgt once within reach.
   function automatic logic [PHI_W-1:0] slew_step(input logic [PHI_W-1:0] cur,
                                                   input logic [PHI_W-1:0] tgt);
      logic signed [PHI_W:0] d;
      d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
      if (d > $signed({1'b0, STEP_MAX}))
         return cur + STEP_MAX;
      else if (d < -$signed({1'b0, STEP_MAX}))
         return cur - STEP_MAX;
      return tgt;
   endfunction

   always_comb w_step = slew_step(r_phi, r_target);
`endif

   always_comb begin
      w_grant0  = bus.req0_valid & (~bus.req1_valid | r_last);
      w_grant1  = bus.req1_valid & (~bus.req0_valid | ~r_last);
      w_xfer    = (r_state == IDLE) & ~reset & (w_grant0 | w_grant1);
      w_sel     = w_grant1;
      w_req_phi = w_sel ? bus.req1_phi : bus.req0_phi;
      w_equal   = (w_req_phi == r_phi);
      w_done    = (r_state == SETTLE) & bus.nco_out_valid & (r_cnt == LAT_M1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_xfer && !w_equal)
`ifdef NCO_TUNE_SLEW_EN
               w_next = RAMP;
`else
               w_next = SETTLE;
`endif
         end
`ifdef NCO_TUNE_SLEW_EN
         RAMP:   if (w_step == r_target) w_next = SETTLE;
`endif
         SETTLE: if (w_done) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_phi       <= RESET_PHI;
         r_last      <= 1'b1;
         r_tuned     <= 1'b0;
         r_tuned_src <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_tuned <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_xfer) begin
                  r_last <= w_sel;
                  r_cnt  <= '0;
                  // Equal target completes immediately without settling.
                  if (w_equal) begin
                     r_tuned     <= 1'b1;
                     r_tuned_src <= w_sel;
                  end
`ifndef NCO_TUNE_SLEW_EN
                  r_phi <= w_req_phi;
`endif
               end
            end
`ifdef NCO_TUNE_SLEW_EN
            RAMP: r_phi <= w_step;
`endif
            SETTLE: begin
               if (bus.nco_out_valid)
                  r_cnt <= r_cnt + 8'd1;
               if (w_done) begin
                  r_tuned     <= 1'b1;
                  r_tuned_src <= r_src;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_xfer) begin
         r_src <= w_sel;
`ifdef NCO_TUNE_SLEW_EN
         r_target <= w_req_phi;
`endif
      end
   end

   always_comb begin
      bus.req0_ready = (r_state == IDLE) & ~reset & w_grant0;
      bus.req1_ready = (r_state == IDLE) & ~reset & w_grant1;
      bus.phi_inc_o  = r_phi;
      bus.busy       = (r_state != IDLE);
      bus.tuned      = r_tuned;
      bus.tuned_src  = r_tuned_src;
   end
endmodule

// File: tb/tb_nco_tune_ctrl.sv
// Directed bench for nco_tune_ctrl with a transaction-level reference model
// checked every cycle plus hand-computed latency/value expectations.
module tb_nco_tune_ctrl;
   localparam int          LAT       = 8;
   localparam logic [31:0] RESET_PHI = 32'h5000_0000;
   localparam logic [31:0] STEP_MAX  = 32'h0010_0000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   nco_tune_ctrl_if #(.PHI_W(32)) bus ();

   nco_tune_ctrl #(.PHI_W(32), .LAT(LAT), .RESET_PHI(RESET_PHI)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // reference model state
   bit          m_init = 0;
   logic [31:0] m_phi;
   bit          m_active, m_tuned, m_tsrc, m_last, m_src;
   int          m_need;
   logic [31:0] m_q[$];

   // observation records
   bit          x0, x1, t_seen, ov_tog;
   int          xfer_cyc, tuned_cyc, tuned_cnt, vcount;
   bit          tuned_src_seen;
   int          grants[$];
   logic [31:0] ph[int];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   task automatic check_cycle();
      bit r0, r1;
      x0 = 0; x1 = 0; t_seen = 0;
      if (!m_init) return;
      r0 = !reset && !m_active && bus.req0_valid && (!bus.req1_valid || m_last);
      r1 = !reset && !m_active && bus.req1_valid && (!bus.req0_valid || !m_last);
      chk("ready0", 32'(bus.req0_ready), 32'(r0));
      chk("ready1", 32'(bus.req1_ready), 32'(r1));
      chk("phi", bus.phi_inc_o, m_phi);
      chk("busy", 32'(bus.busy), 32'(m_active));
      chk("tuned", 32'(bus.tuned), 32'(m_tuned));
      if (m_tuned) chk("tuned_src", 32'(bus.tuned_src), 32'(m_tsrc));
      ph[cyc] = bus.phi_inc_o;
      if (bus.busy && bus.nco_out_valid) vcount++;
      if (bus.req0_valid && bus.req0_ready) begin x0 = 1; xfer_cyc = cyc; vcount = 0; grants.push_back(0); end
      if (bus.req1_valid && bus.req1_ready) begin x1 = 1; xfer_cyc = cyc; vcount = 0; grants.push_back(1); end
      if (bus.tuned) begin
         t_seen = 1; tuned_cyc = cyc; tuned_cnt++; tuned_src_seen = bus.tuned_src;
      end
   endtask

   task automatic model_edge();
      bit g0, g1, k;
      logic [31:0] t, cur;
      if (reset) begin
         m_phi = RESET_PHI; m_active = 0; m_tuned = 0; m_tsrc = 0; m_last = 1;
         m_q.delete(); m_init = 1;
         return;
      end
      if (!m_init) return;
      m_tuned = 0;
      if (!m_active) begin
         g0 = bus.req0_valid && (!bus.req1_valid || m_last);
         g1 = bus.req1_valid && (!bus.req0_valid || !m_last);
         if (g0 || g1) begin
            k = g1;
            t = k ? bus.req1_phi : bus.req0_phi;
            m_last = k;
            if (t == m_phi) begin
               m_tuned = 1; m_tsrc = k;
            end else begin
               m_active = 1; m_src = k; m_need = LAT;
`ifdef NCO_TUNE_SLEW_EN
               cur = m_phi;
               m_q.push_back(cur);
               while (((t > cur) ? (t - cur) : (cur - t)) > STEP_MAX) begin
                  cur = (t > cur) ? cur + STEP_MAX : cur - STEP_MAX;
                  m_q.push_back(cur);
               end
`else
               cur = t;
`endif
               m_q.push_back(t);
               m_phi = m_q.pop_front();
            end
         end
      end else if (m_q.size() > 0) begin
         m_phi = m_q.pop_front();
      end else if (bus.nco_out_valid) begin
         m_need--;
         if (m_need == 0) begin
            m_active = 0; m_tuned = 1; m_tsrc = m_src;
         end
      end
   endtask

   task automatic step();
      #1 check_cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cyc++;
      if (ov_tog) bus.nco_out_valid = ~bus.nco_out_valid;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   task automatic send(input bit k, input logic [31:0] phi);
      bit got = 0;
      if (k) begin bus.req1_valid = 1'b1; bus.req1_phi = phi; end
      else   begin bus.req0_valid = 1'b1; bus.req0_phi = phi; end
      for (int n = 0; n < 3000 && !got; n++) begin
         step();
         got = k ? x1 : x0;
      end
      if (k) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
      chk("handshake", 32'(got), 32'd1);
   endtask

   task automatic wait_tuned();
      bit seen = 0;
      for (int n = 0; n < 3000 && !seen; n++) begin
         step();
         seen = t_seen;
      end
      chk("tuned_timeout", 32'(seen), 32'd1);
   endtask

   initial begin
      int tb_before;
      reset = 1'b1;
      bus.req0_valid = 0; bus.req0_phi = '0;
      bus.req1_valid = 0; bus.req1_phi = '0;
      bus.nco_out_valid = 1'b1;
      ov_tog = 0;
      tuned_cnt = 0; vcount = 0; xfer_cyc = 0; tuned_cyc = 0;
      @(negedge clk);
      idle(3);
      reset = 1'b0;

      // idle after reset
      chk("rst_phi", bus.phi_inc_o, 32'h5000_0000);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      idle(6);
      chk("idle_no_tuned", 32'(tuned_cnt), 32'd0);

      // single request, continuous out_valid
      send(0, 32'h1000_0000);
      wait_tuned();
      chk("single_src", 32'(tuned_src_seen), 32'd0);
      chk("single_phi", bus.phi_inc_o, 32'h1000_0000);
`ifndef NCO_TUNE_SLEW_EN
      chk("single_latency", 32'(tuned_cyc - xfer_cyc), 32'd9);
      chk("single_phi_t1", ph[xfer_cyc + 1], 32'h1000_0000);
`endif
      idle(3);

      // both requesters held: round-robin 0,1,0
      do_reset();
      grants.delete();
      bus.req0_valid = 1; bus.req0_phi = 32'h2000_0000;
      bus.req1_valid = 1; bus.req1_phi = 32'h3000_0000;
      for (int n = 0; n < 6000 && grants.size() < 3; n++) step();
      bus.req0_valid = 0; bus.req1_valid = 0;
      chk("rr_count", 32'(grants.size()), 32'd3);
      if (grants.size() >= 3) begin
         chk("rr_g0", 32'(grants[0]), 32'd0);
         chk("rr_g1", 32'(grants[1]), 32'd1);
         chk("rr_g2", 32'(grants[2]), 32'd0);
      end
      wait_tuned();
      chk("rr_last_src", 32'(tuned_src_seen), 32'd0);

      // toggled out_valid during settle
      ov_tog = 1;
      send(1, 32'h4444_0000);
      wait_tuned();
      ov_tog = 0;
      bus.nco_out_valid = 1'b1;
      chk("toggle_src", 32'(tuned_src_seen), 32'd1);
`ifndef NCO_TUNE_SLEW_EN
      chk("toggle_valid_cycles", 32'(vcount), 32'd8);
`endif

      // reset while a tune is in flight
      send(0, 32'h6000_0000);
      idle(3);
      tb_before = tuned_cnt;
      do_reset();
      idle(15);
      chk("abort_no_tuned", 32'(tuned_cnt), 32'(tb_before));
      chk("abort_phi", bus.phi_inc_o, 32'h5000_0000);

      // equal target right after reset
      do_reset();
      send(1, 32'h5000_0000);
      wait_tuned();
      chk("equal_latency", 32'(tuned_cyc - xfer_cyc), 32'd1);
      chk("equal_src", 32'(tuned_src_seen), 32'd1);
      chk("equal_phi", bus.phi_inc_o, 32'h5000_0000);

`ifdef NCO_TUNE_SLEW_EN
      // slew up then down by three steps
      send(0, 32'h5030_0000);
      wait_tuned();
      chk("slew_up1", ph[xfer_cyc + 2], 32'h5010_0000);
      chk("slew_up2", ph[xfer_cyc + 3], 32'h5020_0000);
      chk("slew_up3", ph[xfer_cyc + 4], 32'h5030_0000);
      chk("slew_up_latency", 32'(tuned_cyc - xfer_cyc), 32'd12);
      send(1, 32'h5000_0000);
      wait_tuned();
      chk("slew_dn1", ph[xfer_cyc + 2], 32'h5020_0000);
      chk("slew_dn2", ph[xfer_cyc + 3], 32'h5010_0000);
      chk("slew_dn3", ph[xfer_cyc + 4], 32'h5000_0000);
`endif
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/nco_tune_ctrl.md
Name: nco_tune_ctrl

Overview:
Tuning controller for the DDC's NCO. It accepts phase-increment (frequency) requests from two requesters over valid/ready, for example a host register port and the AFC loop, and arbitrates between them round-robin. It drives the NCO's 32-bit phi_inc_i, counts the NCO pipeline settle time from its out_valid, and then reports completion. It sits between the control plane and the NCO instance in the DDC.

Parameters:
PHI_W, 32, width of phase-increment word
LAT, 8, NCO output-valid cycles to wait after a phi change before declaring tuned (1..255)
RESET_PHI, 32'h5000_0000, phi_inc_o value after reset
STEP_MAX, 32'h0010_0000, maximum per-cycle phi change when slew feature is compiled in

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 has a tuning word
req0_phi  in  PHI_W  requester 0 target phase increment
req0_ready  out  1  requester 0 transfer accepted this cycle
req1_valid  in  1  requester 1 has a tuning word
req1_phi  in  PHI_W  requester 1 target phase increment
req1_ready  out  1  requester 1 transfer accepted this cycle
nco_out_valid  in  1  NCO out_valid
phi_inc_o  out  PHI_W  to NCO phi_inc_i, registered
busy  out  1  tuning in progress
tuned  out  1  one-cycle pulse, tune complete
tuned_src  out  1  requester index of completed tune, valid with tuned

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset (sync, any state):
  - phi_inc_o=RESET_PHI; busy=0; tuned=0; tuned_src=0.
  - State IDLE; round-robin last-grant pointer=1, so requester 0 wins the first tie.
  - An in-flight tune is aborted and produces no tuned pulse.
- States: IDLE, RAMP (present only with the slew feature), SETTLE.
- Arbitration (combinational, IDLE only):
  - grant0 = req0_valid & (!req1_valid | last==1).
  - grant1 = req1_valid & (!req0_valid | last==0).
  - reqK_ready = (state==IDLE) & grantK. Never both high. Both are 0 outside IDLE and during reset.
- Handshake: transfer when reqK_valid & reqK_ready in cycle T.
  - Latch target=reqK_phi and src=K; set last=K.
  - A requester may drop valid without a transfer; this has no effect.
  - Data is sampled only on the transfer cycle.
- No-slew apply: at T+1, phi_inc_o=target, state SETTLE, cnt=0, busy=1.
- SETTLE:
  - cnt increments on each cycle with nco_out_valid=1. Cycles with nco_out_valid=0 stall the count.
  - On the cycle cnt==LAT-1 with nco_out_valid=1, the next cycle is IDLE with tuned=1, tuned_src=src, busy=0.
  - With continuous out_valid, tuned is at T+LAT+1.
  - A new handshake is allowed in the same cycle tuned is high.
- Equal target: if target==phi_inc_o at transfer, skip SETTLE. Result is tuned=1 at T+1, busy stays 0, phi unchanged.
- tuned is high for exactly one cycle per accepted request. There is no queueing: while busy, both readies are 0.
- phi arithmetic is unsigned PHI_W. No wrap is introduced by the controller.

Optional Feature:
Macro NCO_TUNE_SLEW_EN.
- Defined: after transfer, enter RAMP instead of applying directly.
  - d = target − phi_inc_o as signed PHI_W+1.
  - Each cycle, if |d|>STEP_MAX, phi_inc_o += sign(d)*STEP_MAX (monotonic, never overshoots). Otherwise phi_inc_o=target and go to SETTLE (cnt=0).
  - busy=1 throughout RAMP. Reset in RAMP behaves as normal reset.
- Undefined: RAMP state and STEP_MAX logic are absent; behaviour is the direct apply above.

Test Plan:
- Reset, then idle -> phi_inc_o=32'h5000_0000, busy=0, both readies 0 with no valid, tuned never asserts.
- req0 phi=32'h1000_0000, out_valid=1 constantly -> req0_ready at T, phi_inc_o=32'h1000_0000 at T+1, busy T+1..T+8, tuned=1 & tuned_src=0 at T+9 only.
- req0 and req1 valid together, held, 3 rounds -> grant order 0,1,0, each tuned_src matching, no double ready.
- out_valid toggled 0/1 during SETTLE -> tuned after exactly 8 valid cycles. Reset asserted mid-SETTLE -> no tuned, phi back to 32'h5000_0000.
- Request phi=32'h5000_0000 immediately after reset -> tuned at T+1, busy stays 0.
- With NCO_TUNE_SLEW_EN: req 32'h5000_0000→32'h5030_0000 -> phi steps to 32'h5010_0000, 32'h5020_0000, 32'h5030_0000 on successive cycles, then 8-cycle SETTLE and a tuned pulse. A downward request steps symmetrically.
